// File: rtl/mem_reader.sv
// mem_reader
// Captures the memory unit's stored record on request and streams it out as
// fixed-width chunks over a valid/ready handshake, least-significant chunk first.
//
// Ports:
//   clk          system clock, rising edge
//   arst         synchronous active-high reset
//   mem_dout     stored record from the memory unit (WIDTH bits)
//   rd_req       start a readout (sampled in IDLE only)
//   chunk_out    current chunk (CHUNK bits)
//   chunk_valid  chunk_out holds a valid chunk
//   chunk_ready  consumer accepts chunk_out this cycle
//   chunk_last   current chunk is the final one of the record
//   busy         readout in progress
//
// Optional build macro: AUTO_READ_EN -- a change of mem_dout while idle starts
// a readout without rd_req.
//
// state | meaning
// ------+----------------------------------------------
// IDLE  | waiting for rd_req (or a new record, AUTO_READ_EN)
// SEND  | presenting chunk idx, waiting for the consumer

module mem_reader #(
    parameter  int WIDTH  = 35,
    parameter  int CHUNK  = 7,
    localparam int NCHUNK = WIDTH / CHUNK
) (
    input  logic             clk,
    input  logic             arst,
    input  logic [WIDTH-1:0] mem_dout,
    input  logic             rd_req,
    output logic [CHUNK-1:0] chunk_out,
    output logic             chunk_valid,
    input  logic             chunk_ready,
    output logic             chunk_last,
    output logic             busy
);

    localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(NCHUNK - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             last_q, last_d;
    logic             start;

`ifdef AUTO_READ_EN
    logic [WIDTH-1:0] last_cap_q, last_cap_d;

    assign start = rd_req | (mem_dout != last_cap_q);
`else
    assign start = rd_req;
`endif

    // The shadow shifts down one chunk per transfer, so its low CHUNK bits are
    // always the chunk on the wire. After the final transfer the shadow has
    // been shifted empty, which leaves chunk_out at zero while idle.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
`ifdef AUTO_READ_EN
        last_cap_d = last_cap_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shadow_d = mem_dout;
                    idx_d    = '0;
                    state_d  = ST_SEND;
`ifdef AUTO_READ_EN
                    last_cap_d = mem_dout;
`endif
                end
            end
            ST_SEND: begin
                if (chunk_ready) begin
                    shadow_d = shadow_q >> CHUNK;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
        last_d = (state_d == ST_SEND) && (idx_d == IDX_LAST);
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            shadow_q <= '0;
            last_q   <= 1'b0;
`ifdef AUTO_READ_EN
            last_cap_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            last_q   <= last_d;
`ifdef AUTO_READ_EN
            last_cap_q <= last_cap_d;
`endif
        end
    end

    assign chunk_out   = shadow_q[CHUNK-1:0];
    assign chunk_valid = (state_q == ST_SEND);
    assign busy        = (state_q == ST_SEND);
    assign chunk_last  = last_q;

endmodule

// File: tb/tb_mem_reader.sv
module tb_mem_reader;

    localparam int WIDTH  = 35;
    localparam int CHUNK  = 7;
    localparam int NCHUNK = 5;
    localparam logic [34:0] REC_A  = 35'd63789;
    localparam logic [34:0] REC_MX = 35'h7FFFFFFFF;
`ifdef AUTO_READ_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             arst = 1'b1;
    logic [WIDTH-1:0] mem_dout = '0;
    logic             rd_req = 1'b0;
    logic [CHUNK-1:0] chunk_out;
    logic             chunk_valid;
    logic             chunk_ready = 1'b0;
    logic             chunk_last;
    logic             busy;

    mem_reader #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk         (clk),
        .arst        (arst),
        .mem_dout    (mem_dout),
        .rd_req      (rd_req),
        .chunk_out   (chunk_out),
        .chunk_valid (chunk_valid),
        .chunk_ready (chunk_ready),
        .chunk_last  (chunk_last),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: a record being sent and how many chunks have left.
    bit          m_busy = 1'b0;
    int          m_sent = 0;
    logic [63:0] m_rec  = '0;
    logic [34:0] m_last = '0;
    int          xfers  = 0;
    int          busy_cycles = 0;
    logic [6:0]  got[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_chunk(input logic [63:0] rec, input int k);
        return (rec / (64'd1 << (CHUNK * k))) % 64'd128;
    endfunction

    // One clock: apply inputs at the falling edge, advance the model across
    // the rising edge, then compare DUT outputs against it.
    task automatic cyc(input logic rd, input logic rdy, input logic [34:0] mem, input logic rst);
        rd_req = rd; chunk_ready = rdy; mem_dout = mem; arst = rst;
        #1;
        if (!rst && chunk_valid && chunk_ready) got.push_back(chunk_out);
        if (rst) begin
            m_busy = 1'b0; m_sent = 0; m_last = '0;
        end else if (!m_busy) begin
            if (rd || (AUTO && mem != m_last)) begin
                m_busy = 1'b1; m_sent = 0; m_rec = 64'(mem); m_last = mem;
            end
        end else if (rdy) begin
            xfers++;
            m_sent++;
            if (m_sent == NCHUNK) begin
                m_busy = 1'b0; m_sent = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (busy) busy_cycles++;
        chk("valid", 64'(chunk_valid), 64'(m_busy));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("last", 64'(chunk_last), 64'(m_busy && m_sent == NCHUNK - 1));
        if (m_busy) chk("chunk", 64'(chunk_out), exp_chunk(m_rec, m_sent));
    endtask

    task automatic check_got(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                             input logic [6:0] e2, input logic [6:0] e3, input logic [6:0] e4);
        logic [6:0] e[5];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3; e[4] = e4;
        while (got.size() < NCHUNK) got.push_back('x);
        for (int k = 0; k < NCHUNK; k++) chk(tag, 64'(got[k]), 64'(e[k]));
    endtask

    task automatic begin_scn();
        got.delete();
        xfers = 0;
        busy_cycles = 0;
    endtask

    initial begin
        logic [34:0] rnd;
        @(negedge clk);
        cyc(1'b0, 1'b0, '0, 1'b1);
        cyc(1'b1, 1'b1, '0, 1'b1);
        chk("rst_chunk", 64'(chunk_out), 64'd0);

        // Basic readout
        begin_scn();
        cyc(1'b1, 1'b1, REC_A, 1'b0);
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, REC_A, 1'b0);
        check_got("basic_seq", 7'd45, 7'd114, 7'd3, 7'd0, 7'd0);
        chk("basic_busy_cycles", 64'(busy_cycles), 64'd5);

        // Backpressure on the second chunk
        begin_scn();
        cyc(1'b1, 1'b1, REC_A, 1'b0);
        cyc(1'b0, 1'b1, REC_A, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, REC_A, 1'b0);
            chk("stall_chunk", 64'(chunk_out), 64'd114);
            chk("stall_valid", 64'(chunk_valid), 64'd1);
        end
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, REC_A, 1'b0);
        check_got("bp_seq", 7'd45, 7'd114, 7'd3, 7'd0, 7'd0);

        // Isolation and ignored request
        begin_scn();
        cyc(1'b1, 1'b1, REC_A, 1'b0);
        cyc(1'b0, 1'b1, REC_A, 1'b0);
        cyc(1'b0, 1'b1, REC_A, 1'b0);
        cyc(1'b1, 1'b1, REC_MX, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, REC_MX, 1'b0);
        check_got("iso_seq", 7'd45, 7'd114, 7'd3, 7'd0, 7'd0);
        chk("iso_count", 64'(got.size()), 64'(xfers));

        // Reset after the second transfer
        begin_scn();
        cyc(1'b0, 1'b1, REC_A, 1'b1);
        cyc(1'b1, 1'b1, REC_A, 1'b0);
        cyc(1'b0, 1'b1, REC_A, 1'b0);
        cyc(1'b0, 1'b1, REC_A, 1'b0);
        cyc(1'b1, 1'b0, REC_A, 1'b1);
        chk("mid_rst_chunk", 64'(chunk_out), 64'd0);
        got.delete();
        cyc(1'b1, 1'b1, REC_A, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, REC_A, 1'b0);
        check_got("post_rst_seq", 7'd45, 7'd114, 7'd3, 7'd0, 7'd0);

        // Maximum record
        begin_scn();
        cyc(1'b1, 1'b1, REC_MX, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, REC_MX, 1'b0);
        check_got("max_seq", 7'd127, 7'd127, 7'd127, 7'd127, 7'd127);

        // Change of record without a request
        cyc(1'b0, 1'b1, '0, 1'b1);
        begin_scn();
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, '0, 1'b0);
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, REC_A, 1'b0);
        chk("auto_count", 64'(got.size()), 64'(xfers));
        chk("auto_nchunks", 64'(xfers), AUTO ? 64'd5 : 64'd0);

        // Randomised traffic
        begin_scn();
        rnd = REC_A;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) rnd = 35'({$urandom(), $urandom()});
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0, rnd,
                $urandom_range(0, 60) == 0);
        end
        chk("rand_count", 64'(got.size()), 64'(xfers));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
